n_bit_one_to_four_demux: RTL and testbench
==========================================

# n_bit_one_to_four_demux

Registered 1-to-4 stream distributor: the write-side counterpart of the N-bit 4-to-1 mux. It accepts one N-bit word per cycle on a valid/ready input and routes it into one of four output lanes. Each lane has a one-entry holding register with its own valid/ready handshake. The destination lane comes from an explicit select, or from an internal round-robin pointer.

## Interface
- N, default 5, data width per word and per lane
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  N  input word
- in_sel  in  2  explicit destination lane (00→lane0 … 11→lane3); ignored when rr_en=1
- in_valid  in  1  input word present
- in_ready  out  1  input accepted this cycle when in_valid=1
- rr_en  in  1  1 = destination is rr_ptr; 0 = destination is in_sel
- out_data  out  4*N  lane k occupies bits [k*N +: N]
- out_valid  out  4  lane k holds a word
- out_ready  in  4  lane k consumer accepts
- rr_ptr  out  2  current round-robin destination

## Operation
- Destination: target = rr_en ? rr_ptr : in_sel. This is combinational, so a change on rr_en or in_sel affects the same cycle.
- Handshake on in_ready:
  - in_ready = ~out_valid[target] | out_ready[target].
  - in_ready is combinational from target, out_valid and out_ready.
  - in_ready never depends on in_valid.
- Input transfer occurs when in_valid & in_ready. On the next edge:
  - lane[target] data becomes in_data.
  - out_valid[target] becomes 1.
- Lane drain occurs when out_valid[k] & out_ready[k]. On the next edge, out_valid[k] becomes 0, unless the same lane is refilled in that cycle; then it stays 1 with the new data.
- While out_valid[k]=1 and out_ready[k]=0, lane k data and valid hold stable.
- Lane independence:
  - A stalled lane never blocks words destined for other lanes.
  - A word for a stalled lane blocks the input; there is no reordering or bypass.
- Round-robin pointer:
  - Advances by 1 modulo 4 on each accepted input transfer while rr_en=1 (3 wraps to 0).
  - Holds when there is no transfer, when the input is stalled, or when rr_en=0.
  - Toggling rr_en does not reset rr_ptr.
- Lanes without a transfer keep their data and valid.

## Timing
- Latency: 1 cycle from accepted input to out_valid on the lane.
- Throughput: 1 word/cycle sustained, including back-to-back words to the same lane when that lane's out_ready=1 (drain and refill in the same cycle, no bubble).
- Reset values, applied immediately when rst_n falls and independent of clk:
  - out_valid = 4'b0000
  - out_data = 0
  - rr_ptr = 2'b00
  - in_ready = 1 (follows from the cleared lanes)
- Reset mid-operation: held words are dropped. An in-flight transfer on the edge coincident with reset is not captured.
- First possible capture is the first rising edge after rst_n deasserts.

## Structure
- Shared package holds:
  - LANES = 4
  - SEL_W = 2
  - the lane index-to-slice convention (k*N +: N), which is also used by the mux side
- Sub-module demux_lane_reg (parameter N), instantiated 4 times in a generate loop. It contains one data register and one valid flop, with inputs load, load_data, drain, clk and rst_n.
- The top level holds:
  - target selection
  - in_ready logic
  - one-hot load decode
  - the rr_ptr counter

## Test plan
- Reset: pulse rst_n low between edges with lanes 0 and 3 full. Require out_valid=0000, out_data=0, rr_ptr=00 and in_ready=1 before the next edge.
- Explicit route: N=5, rr_en=0, in_sel=10, in_data=5'h15, in_valid for 1 cycle, out_ready=1111. Require out_valid=0100 and out_data[14:10]=5'h15 on the next cycle, cleared the cycle after.
- Backpressure isolation:
  - Stimulus: out_ready[1]=0; send 5'h03 to lane1, then 5'h04 to lane1, then 5'h07 to lane0.
  - Lane1 must hold 5'h03 with in_ready=0 during the second word.
  - Lane0 must stay empty until lane1 drains.
  - Raising out_ready[1] must drain 5'h03, and 5'h04 must appear one cycle later.
- Drain+refill: lane2 full with 5'h0A, out_ready[2]=1, input 5'h0B to lane2 in the same cycle. Require in_ready=1 and lane2=5'h0B with out_valid[2] held at 1 with no gap.
- Round-robin:
  - Stimulus: rr_en=1, consecutive words 5'h01..5'h05, all out_ready=1.
  - Require routing to lanes 0,1,2,3,0 and rr_ptr=01 at the end.
  - With out_ready[1]=0 and lane1 full, require rr_ptr to stay 01 and in_ready=0 until the lane drains.
- Select change: rr_en=0, in_valid held, in_sel switched from a stalled lane to an empty lane mid-stall. Require in_ready to rise in the same cycle and the word to land in the new lane.

Source files
------------

// File: rtl/n_bit_one_to_four_demux_pkg.sv
// Shared constants for the 1-to-4 demux and its 4-to-1 mux counterpart.
// Lane k of a packed 4*N bus always sits at [lane_lsb(k, N) +: N].
package n_bit_one_to_four_demux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  function automatic int lane_lsb(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/n_bit_one_to_four_demux_lane_reg.sv
// One-entry lane holding register: a load takes priority over a drain.
// That priority lets a lane drain and refill in the same cycle without a bubble.
module demux_lane_reg #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         drain,
  output logic [N-1:0] lane_data,
  output logic         lane_valid
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = load ? load_data : data_q;
    valid_d = load | (valid_q & ~drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign lane_data  = data_q;
  assign lane_valid = valid_q;

endmodule

// File: rtl/n_bit_one_to_four_demux.sv
// Registered 1-to-4 stream distributor with explicit or round-robin lane choice.
// Only the targeted lane gates in_ready, so a stalled lane never blocks the others.
module n_bit_one_to_four_demux
  import n_bit_one_to_four_demux_pkg::*;
#(
  parameter int N = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               rr_en,
  output logic [LANES*N-1:0] out_data,
  output logic [LANES-1:0]   out_valid,
  input  logic [LANES-1:0]   out_ready,
  output logic [SEL_W-1:0]   rr_ptr
);

  lane_sel_t        rr_ptr_q, rr_ptr_d;
  lane_sel_t        target;
  logic             xfer;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;

  assign target   = rr_en ? rr_ptr_q : in_sel;
  assign in_ready = ~out_valid[target] | out_ready[target];
  assign xfer     = in_valid & in_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && rr_en) begin
      rr_ptr_d = rr_ptr_q + lane_sel_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign load[k]  = xfer & (target == SEL_W'(k));
    assign drain[k] = out_valid[k] & out_ready[k];

    demux_lane_reg #(
      .N(N)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .drain     (drain[k]),
      .lane_data (out_data[lane_lsb(k, N) +: N]),
      .lane_valid(out_valid[k])
    );
  end

endmodule

// File: tb/tb_n_bit_one_to_four_demux.sv
// Bench for the 1-to-4 demux: directed vector table, reset sequences, then random traffic vs. a lane model.
module tb_n_bit_one_to_four_demux;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         rr_en;
  logic [4*N-1:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [1:0]   rr_ptr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  n_bit_one_to_four_demux #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rr_en    (rr_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rr_ptr   (rr_ptr)
  );

  typedef struct {
    logic         rr;
    logic [1:0]   sel;
    logic [N-1:0] dat;
    logic         vld;
    logic [3:0]   ordy;
    logic         exp_rdy;
    logic [3:0]   exp_ov;
    int           lane;
    logic [N-1:0] exp_ldat;
    logic [1:0]   exp_ptr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rr, input logic [1:0] sel, input logic [N-1:0] dat,
                     input logic vld, input logic [3:0] ordy, input logic rdy,
                     input logic [3:0] ov, input int lane, input logic [N-1:0] ldat,
                     input logic [1:0] ptr);
    vec_t v;
    v.rr = rr; v.sel = sel; v.dat = dat; v.vld = vld; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.lane = lane; v.exp_ldat = ldat; v.exp_ptr = ptr;
    vecs.push_back(v);
  endtask

  function automatic logic [N-1:0] lane_of(input int k);
    return out_data[k*N +: N];
  endfunction

  // Reference lane state for the random phase
  logic         m_vld[4];
  logic [N-1:0] m_dat[4];
  int           m_ptr;

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; rr_en = 1'b0; out_ready = '0;

    //   rr sel  dat   vld ordy    rdy ov      lane ldat  ptr
    add(0, 2, 5'h15, 1, 4'b1111, 1, 4'b0100, 2, 5'h15, 0); // explicit route
    add(0, 2, 5'h00, 0, 4'b1111, 1, 4'b0000, 2, 5'h15, 0);
    add(0, 1, 5'h03, 1, 4'b1101, 1, 4'b0010, 1, 5'h03, 0); // backpressure isolation
    add(0, 1, 5'h04, 1, 4'b1101, 0, 4'b0010, 1, 5'h03, 0);
    add(0, 1, 5'h04, 1, 4'b1101, 0, 4'b0010, 1, 5'h03, 0);
    add(0, 1, 5'h04, 1, 4'b1111, 1, 4'b0010, 1, 5'h04, 0);
    add(0, 0, 5'h07, 1, 4'b1111, 1, 4'b0001, 0, 5'h07, 0);
    add(0, 2, 5'h0A, 1, 4'b1111, 1, 4'b0100, 2, 5'h0A, 0); // drain + refill
    add(0, 2, 5'h0B, 1, 4'b1111, 1, 4'b0100, 2, 5'h0B, 0);
    add(0, 2, 5'h00, 0, 4'b1111, 1, 4'b0000, 2, 5'h0B, 0);
    add(1, 3, 5'h01, 1, 4'b1111, 1, 4'b0001, 0, 5'h01, 1); // round robin
    add(1, 3, 5'h02, 1, 4'b1111, 1, 4'b0010, 1, 5'h02, 2);
    add(1, 3, 5'h03, 1, 4'b1111, 1, 4'b0100, 2, 5'h03, 3);
    add(1, 3, 5'h04, 1, 4'b1111, 1, 4'b1000, 3, 5'h04, 0);
    add(1, 3, 5'h05, 1, 4'b1111, 1, 4'b0001, 0, 5'h05, 1);
    add(0, 1, 5'h06, 1, 4'b1101, 1, 4'b0010, 1, 5'h06, 1);
    add(1, 0, 5'h07, 1, 4'b1101, 0, 4'b0010, 1, 5'h06, 1);
    add(1, 0, 5'h07, 1, 4'b1101, 0, 4'b0010, 1, 5'h06, 1);
    add(1, 0, 5'h07, 1, 4'b1111, 1, 4'b0010, 1, 5'h07, 2);
    add(0, 1, 5'h08, 1, 4'b1101, 0, 4'b0010, 1, 5'h07, 2); // select change
    add(0, 3, 5'h08, 1, 4'b1101, 1, 4'b1010, 3, 5'h08, 2);
    add(0, 0, 5'h00, 0, 4'b1111, 1, 4'b0000, 3, 5'h08, 2);

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rr_en = vecs[i].rr; in_sel = vecs[i].sel; in_data = vecs[i].dat;
      in_valid = vecs[i].vld; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("row%0d_lane%0d_data", i, vecs[i].lane), 32'(lane_of(vecs[i].lane)),
          32'(vecs[i].exp_ldat));
      chk($sformatf("row%0d_rr_ptr", i), 32'(rr_ptr), 32'(vecs[i].exp_ptr));
    end

    // Mid-operation reset with lanes 0 and 3 full, pulsed between edges
    rr_en = 1'b0; out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 5'h1F;
    @(posedge clk); #1;
    in_sel = 2'd3; in_data = 5'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("prefill_out_valid", 32'(out_valid), 32'h9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_out_data", 32'(out_data), 32'h0);
    chk("async_rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h1);
    #1 rst_n = 1'b1;

    // Transfer offered on an edge while reset is held must be dropped
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 5'h0C; out_ready = 4'b0000;
    @(posedge clk); #1;
    chk("rst_edge_no_capture", 32'(out_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_capture_valid", 32'(out_valid), 32'h4);
    chk("first_capture_data", 32'(lane_of(2)), 32'h0C);

    for (int k = 0; k < 4; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
    end
    m_vld[2] = 1'b1; m_dat[2] = 5'h0C; m_ptr = 0;

    // Random traffic against the lane model
    for (int c = 0; c < 400; c++) begin
      int  tgt;
      logic exp_rdy;
      rr_en     = ($urandom_range(0, 2) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = N'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 4'($urandom);
      tgt = rr_en ? m_ptr : int'(in_sel);
      exp_rdy = !m_vld[tgt] || out_ready[tgt];
      @(negedge clk);
      chk($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy));
      for (int k = 0; k < 4; k++) begin
        if (m_vld[k] && out_ready[k]) m_vld[k] = 1'b0;
      end
      if (in_valid && exp_rdy) begin
        m_vld[tgt] = 1'b1;
        m_dat[tgt] = in_data;
        if (rr_en) m_ptr = (m_ptr + 1) % 4;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rnd%0d_valid%0d", c, k), 32'(out_valid[k]), 32'(m_vld[k]));
        chk($sformatf("rnd%0d_data%0d", c, k), 32'(lane_of(k)), 32'(m_dat[k]));
      end
      chk($sformatf("rnd%0d_rr_ptr", c), 32'(rr_ptr), 32'(m_ptr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
